// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-client round-robin arbiter with an optional hold-time
// limit. Grants are registered; a single idle bubble cycle always separates
// two grants, and the rotating pointer always moves past the last owner.
// Handshake: a client holds req high for as long as it needs the resource and
// owns it while its gnt bit is high; dropping req releases the grant on the
// next edge. A grant removed by hold-limit expiry is flagged by a
// one-cycle preempt pulse.
module rr_arbiter4 #(
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       preempt
);

   localparam int            CW       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
   localparam bit            LIMIT_EN = (HOLD_MAX != 0);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    gnt_idx_q, gnt_idx_d;
   logic          gnt_valid_q, gnt_valid_d;
   logic          preempt_q, preempt_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          pick_found;
   logic [1:0]    pick_idx;
   logic          owner_req;
   logic          others_req;
   logic          at_limit;

   // Round-robin scan: first asserted request starting at ptr, wrapping mod 4.
   always_comb begin
      logic [1:0] cand;
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      cand       = ptr_q;
      for (int off = 0; off < 4; off++) begin
         cand = ptr_q + 2'(off);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Owner status and hold-limit condition for the current grant.
   always_comb begin
      owner_req  = req[gnt_idx_q];
      others_req = |(req & ~gnt_q);
      at_limit   = LIMIT_EN && (cnt_q == HOLD_LIM);
   end

   // Next-state and next-output computation for the IDLE/GRANT machine.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      preempt_d   = 1'b0;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d     = GRANT;
               gnt_d       = 4'b0001 << pick_idx;
               gnt_idx_d   = pick_idx;
               gnt_valid_d = 1'b1;
               cnt_d       = LIMIT_EN ? CW'(1) : '0;
            end
         end
         GRANT: begin
            // Release takes priority: preempt only flags when the owner still wants it.
            if (!owner_req || (at_limit && others_req)) begin
               state_d     = IDLE;
               gnt_d       = 4'b0000;
               gnt_idx_d   = 2'd0;
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_idx_q + 2'd1;
               cnt_d       = '0;
               preempt_d   = owner_req;
            end else if (LIMIT_EN && !at_limit) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = 4'b0000;
            gnt_idx_d   = 2'd0;
            gnt_valid_d = 1'b0;
            cnt_d       = '0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= 4'b0000;
         gnt_idx_q   <= 2'd0;
         gnt_valid_q <= 1'b0;
         preempt_q   <= 1'b0;
         ptr_q       <= 2'd0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         preempt_q   <= preempt_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4 with HOLD_MAX=4: cycle vectors with expected outputs,
// a hand-written asynchronous-reset sequence, and a random invariant phase.
module tb_rr_arbiter4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   rr_arbiter4 #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   // Clock.
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [3:0] rq;
      logic [3:0] g;
      logic [1:0] ix;
      logic       v;
      logic       p;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   int         total = 0;
   int         bad   = 0;

   function automatic void add_vec(input logic r, input logic [3:0] rq, input logic [3:0] g,
                                   input logic [1:0] ix, input logic v, input logic p);
      vec_t e;
      e.r = r; e.rq = rq; e.g = g; e.ix = ix; e.v = v; e.p = p;
      vecs.push_back(e);
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got gnt=%b idx=%0d valid=%b pre=%b, want gnt=%b idx=%0d valid=%b pre=%b",
                  name, got[7:4], got[3:2], got[1], got[0], expv[7:4], expv[3:2], expv[1], expv[0]);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic run_vec(input vec_t e, input int n);
      string nm;
      rst = e.r;
      req = e.rq;
      exp_q.push_back({e.g, e.ix, e.v, e.p});
      @(posedge clk);
      #1;
      nm = $sformatf("vec%0d", n);
      check(nm, {gnt, gnt_idx, gnt_valid, preempt}, exp_q.pop_front());
   endtask

   logic [3:0] prev_gnt;
   logic [1:0] enc;
   logic       ok;

   initial begin
      // Reset state, checked while reset is held.
      #1;
      check("reset_state", {gnt, gnt_idx, gnt_valid, preempt}, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single request, grant, saturate, release.
      add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      for (int i = 0; i < 5; i++) add_vec(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
      add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // Reset pointer, then rotate through all four with 2-cycle holds.
      add_vec(1, 4'b0000, 4'b0000, 2'd0, 0, 0);
      add_vec(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
      add_vec(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
      add_vec(0, 4'b1110, 4'b0000, 2'd0, 0, 0);
      add_vec(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
      add_vec(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
      add_vec(0, 4'b1101, 4'b0000, 2'd0, 0, 0);
      add_vec(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
      add_vec(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
      add_vec(0, 4'b1011, 4'b0000, 2'd0, 0, 0);
      add_vec(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
      add_vec(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
      add_vec(0, 4'b0111, 4'b0000, 2'd0, 0, 0);
      add_vec(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
      add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // Hold-limit preemption: 4 grant cycles, preempt bubble, then client 1.
      add_vec(0, 4'b0001, 4'b0001, 2'd0, 1, 0);
      for (int i = 0; i < 3; i++) add_vec(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
      add_vec(0, 4'b0011, 4'b0000, 2'd0, 0, 1);
      add_vec(0, 4'b0011, 4'b0010, 2'd1, 1, 0);
      add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // Saturated hold with no competitor, then a late competitor.
      for (int i = 0; i < 10; i++) add_vec(0, 4'b0001, 4'b0001, 2'd0, 1, 0);
      add_vec(0, 4'b1001, 4'b0000, 2'd0, 0, 1);
      add_vec(0, 4'b1001, 4'b1000, 2'd3, 1, 0);
      add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
      // Release and expiry on the same edge: release wins, no preempt.
      add_vec(0, 4'b0001, 4'b0001, 2'd0, 1, 0);
      for (int i = 0; i < 3; i++) add_vec(0, 4'b0101, 4'b0001, 2'd0, 1, 0);
      add_vec(0, 4'b0100, 4'b0000, 2'd0, 0, 0);
      add_vec(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
      add_vec(0, 4'b0000, 4'b0000, 2'd0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Asynchronous reset in the middle of a grant to client 2.
      begin
         vec_t e;
         e.r = 0; e.rq = 4'b0100; e.g = 4'b0100; e.ix = 2'd2; e.v = 1; e.p = 0;
         run_vec(e, 100);
         #2;
         rst = 1'b1;
         #1;
         check("async_rst", {gnt, gnt_idx, gnt_valid, preempt}, 8'h00);
         req = 4'b1111;
         @(posedge clk);
         #1;
         e.r = 0; e.rq = 4'b1111; e.g = 4'b0001; e.ix = 2'd0; e.v = 1; e.p = 0;
         run_vec(e, 101);
         e.r = 0; e.rq = 4'b0000; e.g = 4'b0000; e.ix = 2'd0; e.v = 0; e.p = 0;
         run_vec(e, 102);
      end

      // Random requests: structural invariants every cycle.
      prev_gnt = gnt;
      for (int c = 0; c < 400; c++) begin
         req = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
         enc = 2'd0;
         for (int b = 0; b < 4; b++) if (gnt[b]) enc = 2'(b);
         ok = $onehot0(gnt) && (gnt_valid == (|gnt)) && (gnt_idx == enc)
              && !(preempt && (|gnt))
              && !((|prev_gnt) && (|gnt) && (gnt != prev_gnt));
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL invariants cycle %0d: gnt=%b prev=%b idx=%0d valid=%b pre=%b",
                     c, gnt, prev_gnt, gnt_idx, gnt_valid, preempt);
         end
         prev_gnt = gnt;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
